// File: rtl/mips_trace_buf_if.sv
// Capture/readout bundle for the MIPS execution trace buffer.
// The master drives capture and readout-ready; the slave returns status and trace entries.
interface mips_trace_buf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned FILL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned INSTR_W = 32;

  logic                arm;
  logic [ADDR_W-1:0]   trig_pc;
  logic                cap_valid;
  logic [ADDR_W-1:0]   cap_pc;
  logic [INSTR_W-1:0]  cap_instr;
  logic [DATA_W-1:0]   cap_result;
  logic                armed;
  logic                triggered;
  logic [FILL_W-1:0]   fill;
  logic                rd_valid;
  logic                rd_ready;
  logic [ADDR_W-1:0]   rd_pc;
  logic [INSTR_W-1:0]  rd_instr;
  logic [DATA_W-1:0]   rd_result;
  logic                rd_last;

  modport master (
    output arm, trig_pc, cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
    input  armed, triggered, fill, rd_valid, rd_pc, rd_instr, rd_result, rd_last
  );

  modport slave (
    input  arm, trig_pc, cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
    output armed, triggered, fill, rd_valid, rd_pc, rd_instr, rd_result, rd_last
  );
endinterface

// File: rtl/mips_trace_buf.sv
// Circular execution-trace buffer: captures retired instructions until a PC trigger
// plus POST_TRIG entries, then streams the history oldest-first.
module mips_trace_buf #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input logic             clk,
  input logic             rst,
  mips_trace_buf_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned FILL_W  = PTR_W + 1;
  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  result;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ARMED, POST, READ} state_t;

  state_t            state, state_nxt;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt_c;
  logic [FILL_W-1:0] fill, fill_nxt_c, remain, post_cnt;
  logic              capturing_c, wr_en_c, hit_c, last_cap_c;
  entry_t            wr_entry_c, rd_entry_c;

  assign capturing_c  = (state == ARMED) || (state == POST);
  assign wr_en_c      = capturing_c && bus.cap_valid;
  assign hit_c        = bus.cap_valid && (bus.cap_pc == bus.trig_pc);
  assign last_cap_c   = bus.cap_valid && (post_cnt == FILL_W'(1));
  assign wr_ptr_nxt_c = wr_ptr + PTR_W'(1);
  assign fill_nxt_c   = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
  assign wr_entry_c   = '{pc: bus.cap_pc, instr: bus.cap_instr, result: bus.cap_result};
  assign rd_entry_c   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.arm) state_nxt = ARMED;
      ARMED:   if (hit_c) state_nxt = (POST_TRIG == 1) ? READ : POST;
      POST:    if (last_cap_c) state_nxt = READ;
      READ:    if (bus.rd_ready && (remain == FILL_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, fill level and counters; readout pointer snaps to the oldest entry on entering READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      remain   <= '0;
      post_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
          end
        end
        ARMED, POST: begin
          if (wr_en_c) begin
            wr_ptr <= wr_ptr_nxt_c;
            fill   <= fill_nxt_c;
            if (state == ARMED) begin
              if (hit_c) post_cnt <= FILL_W'(POST_TRIG - 1);
            end else begin
              post_cnt <= post_cnt - FILL_W'(1);
            end
          end
          if (state_nxt == READ) begin
            rd_ptr <= wr_ptr_nxt_c - PTR_W'(fill_nxt_c);
            remain <= fill_nxt_c;
          end
        end
        READ: begin
          if (bus.rd_ready) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            remain <= remain - FILL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Trace storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= wr_entry_c;
  end

  assign bus.armed     = capturing_c;
  assign bus.triggered = (state == POST) || (state == READ);
  assign bus.fill      = fill;
  assign bus.rd_valid  = (state == READ);
  assign bus.rd_last   = (state == READ) && (remain == FILL_W'(1));
  assign bus.rd_pc     = rd_entry_c.pc;
  assign bus.rd_instr  = rd_entry_c.instr;
  assign bus.rd_result = rd_entry_c.result;
endmodule
